// File: rtl/hav_dist_solver.sv
`timescale 1ns/1ps
// hav_dist_solver
//   Back end of the haversine datapath. Takes the haversine term
//   a = sin^2(dlat/2) + cosA*cosB*sin^2(dlon/2) (unsigned Q0.64) and
//   returns d = 2*R*asin(sqrt(a)) (unsigned Q16.16 km).
//   Flow: bit-serial restoring sqrt (32 cycles) -> optional cubic asin
//   correction -> scale by 2*R_KM -> hold result until accepted.
//
//   Optional feature macro: HAV_ASIN_CORR_EN
//     defined   : CORR1..CORR3 add asin(s) ~ s + s^3/6 (one shared 32x32 multiplier)
//     undefined : asin(s) ~ s
//
// Parameters
//   R_KM       Earth radius in km, 1..32767
// Ports
//   clk        clock, rising edge
//   reset_n    synchronous active-low reset
//   in_valid   a_in valid
//   in_ready   block can accept a_in (IDLE only)
//   a_in       haversine term, unsigned Q0.64
//   out_valid  dist_out valid, held until out_ready
//   out_ready  downstream accepts dist_out
//   dist_out   distance, unsigned Q16.16 km
module hav_dist_solver #(
    parameter int unsigned R_KM = 6371
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dist_out
);

    localparam int unsigned ROOT_W = 32;
    localparam int unsigned REM_W  = 34;
    localparam int unsigned CNT_W  = 5;
    localparam logic [31:0] TWO_R  = 32'(2 * R_KM);
`ifdef HAV_ASIN_CORR_EN
    localparam logic [31:0] INV6   = 32'h2AAA_AAAB;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SQRT  = 3'd1,
        CORR1 = 3'd2,
        CORR2 = 3'd3,
        CORR3 = 3'd4,
        SCALE = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic                out_valid_q, out_valid_d;
    logic                in_ready_q,  in_ready_d;
    logic [31:0]         dist_q;
    logic [63:0]         a_q;
    logic [REM_W-1:0]    rem_q;
    logic [ROOT_W-1:0]   root_q;
    logic [CNT_W-1:0]    cnt_q;
`ifdef HAV_ASIN_CORR_EN
    logic [31:0]         tmp_q;
    logic [32:0]         corr_sum;
`endif

    logic                accept;
    logic [REM_W+1:0]    rem_t, trial, rem_sub;
    logic                bit_ge;
    logic [31:0]         mul_a, mul_b;
    logic [63:0]         prod;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dist_out  = dist_q;
    assign accept    = in_valid && in_ready_q;

    // Restoring sqrt step: bring down two radicand bits, try subtracting 4*root+1
    assign rem_t   = {rem_q, a_q[63:62]};
    assign trial   = {2'b00, root_q, 2'b01};
    assign bit_ge  = (rem_t >= trial);
    assign rem_sub = rem_t - trial;

    // Shared multiplier operand select
    always_comb begin
        mul_a = TWO_R;
        mul_b = root_q;
`ifdef HAV_ASIN_CORR_EN
        case (state_q)
            CORR1: begin mul_a = root_q; mul_b = root_q; end
            CORR2: begin mul_a = tmp_q;  mul_b = root_q; end
            CORR3: begin mul_a = tmp_q;  mul_b = INV6;   end
            default: ;
        endcase
`endif
    end

    assign prod = 64'(mul_a) * 64'(mul_b);

`ifdef HAV_ASIN_CORR_EN
    assign corr_sum = {1'b0, root_q} + {1'b0, 32'(prod >> 32)};
`endif

    // State and handshake output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE:  if (accept) state_d = SQRT;
            SQRT: begin
                if (cnt_q == '0) begin
`ifdef HAV_ASIN_CORR_EN
                    state_d = CORR1;
`else
                    state_d = SCALE;
`endif
                end
            end
`ifdef HAV_ASIN_CORR_EN
            CORR1: state_d = CORR2;
            CORR2: state_d = CORR3;
            CORR3: state_d = SCALE;
`endif
            SCALE: state_d = DONE;
            DONE: begin
                if (out_valid_q && out_ready) state_d = IDLE;
                else                          out_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q    <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            dist_q <= '0;
`ifdef HAV_ASIN_CORR_EN
            tmp_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q    <= a_in;
                        rem_q  <= '0;
                        root_q <= '0;
                        cnt_q  <= CNT_W'(31);
                    end
                end
                SQRT: begin
                    a_q    <= {a_q[61:0], 2'b00};
                    rem_q  <= REM_W'(bit_ge ? rem_sub : rem_t);
                    root_q <= {root_q[ROOT_W-2:0], bit_ge};
                    cnt_q  <= cnt_q - CNT_W'(1);
                end
`ifdef HAV_ASIN_CORR_EN
                CORR1: tmp_q <= 32'(prod >> 32);
                CORR2: tmp_q <= 32'(prod >> 32);
                CORR3: root_q <= corr_sum[32] ? 32'hFFFF_FFFF : corr_sum[31:0];
`endif
                SCALE: dist_q <= 32'(prod >> 16);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hav_dist_solver.sv
`timescale 1ns/1ps
// Testbench for hav_dist_solver: scoreboard of expected distances, directed
// boundary jobs, backpressure, mid-job reset and random a_in.
module tb_hav_dist_solver;

    localparam int unsigned R_KM = 6371;
`ifdef HAV_ASIN_CORR_EN
    localparam int unsigned LAT     = 37;
    localparam logic [31:0] EXP_QTR = 32'h19EC_7555;
`else
    localparam int unsigned LAT     = 34;
    localparam logic [31:0] EXP_QTR = 32'h18E3_0000;
`endif
    localparam logic [63:0] A_QTR  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] A_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dist_out;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    hav_dist_solver #(.R_KM(R_KM)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dist_out  (dist_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: integer sqrt by bitwise search on s*s <= a, then asin and scale
    function automatic logic [31:0] model(input logic [63:0] a);
        logic [31:0] s;
        logic [31:0] cand;
        logic [63:0] p;
`ifdef HAV_ASIN_CORR_EN
        logic [63:0] s2, s3, c, sum;
`endif
        s = '0;
        for (int b = 31; b >= 0; b--) begin
            cand = s | (32'd1 << b);
            if (64'(cand) * 64'(cand) <= a) s = cand;
        end
`ifdef HAV_ASIN_CORR_EN
        s2  = (64'(s) * 64'(s)) >> 32;
        s3  = (s2 * 64'(s)) >> 32;
        c   = (s3 * 64'h2AAA_AAAB) >> 32;
        sum = 64'(s) + c;
        s   = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
`endif
        p = 64'(2 * R_KM) * 64'(s);
        return 32'(p >> 16);
    endfunction

    // Scoreboard: compare on each output handshake
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected_out", 64'(exp_q.size()), 64'd1);
            else                   check("sb_dist", 64'(dist_out), 64'(exp_q.pop_front()));
        end
    end

    // One job: wait for in_ready, accept, measure latency to out_valid
    task automatic do_job(input logic [63:0] a, input bit chk_lat, output logic [31:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) check("in_ready_timeout", 64'(n), 64'd0);
        in_valid = 1'b1;
        a_in     = a;
        @(posedge clk);
        exp_q.push_back(model(a));
        #1;
        in_valid = 1'b0;
        a_in     = {$urandom, $urandom};
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100)    check("out_valid_timeout", 64'(n), 64'(LAT));
        else if (chk_lat) check("latency", 64'(n), 64'(LAT));
        d = dist_out;
        if (out_ready) begin
            @(posedge clk); #1;
            check("out_valid_one_cycle", 64'(out_valid), 64'd0);
            check("in_ready_after_hs", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [63:0] a;
        int          cnt;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dist", 64'(dist_out), 64'd0);
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready_high", 64'(in_ready), 64'd1);

        // Directed values and boundaries
        do_job(A_QTR, 1'b1, d);
        check("quarter", 64'(d), 64'(EXP_QTR));
        do_job(64'd0, 1'b1, d);
        check("zero", 64'(d), 64'd0);
        do_job(A_ONES, 1'b1, d);
        check("all_ones", 64'(d), 64'h31C5_FFFF);
        do_job(64'd1, 1'b1, d);
        do_job(64'd3, 1'b0, d);

        // Backpressure: result held, new request ignored
        out_ready = 1'b0;
        do_job(A_QTR, 1'b1, d);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                in_valid = 1'b1;
                a_in     = 64'h1234_5678_9ABC_DEF0;
            end
            @(posedge clk); #1;
            check("bp_dist_stable", 64'(dist_out), 64'(d));
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ov", 64'(out_valid), 64'd0);
        check("bp_release_ir", 64'(in_ready), 64'd1);
        do_job(64'h0000_0001_0000_0000, 1'b1, d);

        // Reset during SQRT aborts the job
        in_valid = 1'b1;
        a_in     = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_dist", 64'(dist_out), 64'd0);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        check("midrst_no_output", 64'(cnt), 64'd0);
        do_job(A_QTR, 1'b1, d);
        check("midrst_next_job", 64'(d), 64'(EXP_QTR));

        // Random jobs against the model
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom};
            if (i % 4 == 1) a = a >> $urandom_range(1, 63);
            do_job(a, (i < 16), d);
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
